// File: rtl/cdc_fanin_arbiter.sv
// cdc_fanin_arbiter: destination-domain round-robin fan-in of N 4-phase req/ack sources onto one valid/ready port
// Ports:
//   clk, rst     destination clock, synchronous active-high reset
//   req_in[N]    per-source level request (asynchronous to clk)
//   data_in[N*W] per-source word, slice i = [i*W +: W], stable while its req is high
//   ack_out[N]   per-source acknowledge (registered)
//   out_valid/out_ready/out_data/out_src  downstream valid/ready port with source index
//   err          sticky handshake-timeout flag
// Optional: define ARB_TIMEOUT_EN to abandon a handshake after TIMEOUT_CYC cycles in WAIT_DROP and set err.
module cdc_fanin_arbiter #(
  parameter int N = 3,
  parameter int W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   ack_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           err
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DROP} state_t;
  state_t state;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] req_sync, pending;
  logic [SW-1:0] ptr, win, idx;
  logic timeout;
  assign req_sync = sync_q[SYNC_STAGES-1];
  assign pending = req_sync & ~ack_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  // Scan from the farthest candidate back to ptr so the nearest pending source at or after ptr wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr) + k) % N);
      if (pending[idx]) win = idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      ack_out <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          out_data <= data_in[int'(win)*W +: W];
          out_src <= win;
          out_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          ack_out <= N'(1) << out_src;
          ptr <= (out_src == SW'(N - 1)) ? '0 : out_src + 1'b1;
          state <= WAIT_DROP;
        end
        WAIT_DROP: if (!req_sync[out_src] || timeout) begin
          ack_out <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [31:0] cnt;
  // Fires on the TIMEOUT_CYC-th WAIT_DROP edge that still sees the winner's request high.
  assign timeout = (state == WAIT_DROP) && req_sync[out_src] && (cnt == 32'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == WAIT_DROP && !timeout) ? cnt + 1'b1 : '0;
      err <= err | timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_fanin_arbiter.sv
// tb_cdc_fanin_arbiter: table vectors, directed corner sequences and randomized sources against a transaction model
module tb_cdc_fanin_arbiter;
  localparam int N = 3, W = 8, SW = 2, TO = 8;
  logic clk = 1'b0;
  logic rst, out_valid, out_ready, err;
  logic [N-1:0] req_in, ack_out;
  logic [N*W-1:0] data_in;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_src;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  cdc_fanin_arbiter #(.N(N), .W(W), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .err(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask
  typedef struct {
    logic [N-1:0] req;
    logic [N*W-1:0] data;
    logic [SW-1:0] exp_src;
    logic [W-1:0] exp_data;
  } vec_t;
  vec_t tbl[8];
  int st[N], dly[N], oth[N];
  logic [W-1:0] sd[N];
  logic pv, pr;
  logic [SW-1:0] ps;
  logic [W-1:0] pd;
  logic [SW-1:0] order[6];
  int served;
  initial begin
    // Expected winners follow ptr carried across records (ptr 0 after reset).
    tbl[0] = '{3'b010, 24'h33A511, 2'd1, 8'hA5};
    tbl[1] = '{3'b101, 24'h440055, 2'd2, 8'h44};
    tbl[2] = '{3'b011, 24'h006677, 2'd0, 8'h77};
    tbl[3] = '{3'b001, 24'h000088, 2'd0, 8'h88};
    tbl[4] = '{3'b111, 24'hCCBBAA, 2'd1, 8'hBB};
    tbl[5] = '{3'b110, 24'hEEDD00, 2'd2, 8'hEE};
    tbl[6] = '{3'b100, 24'h990000, 2'd2, 8'h99};
    tbl[7] = '{3'b110, 24'h123400, 2'd1, 8'h34};
    rst = 1'b1;
    req_in = '0;
    data_in = '0;
    out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_state", {ack_out, out_valid, out_src, err}, 0);
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk("idle_quiet", {ack_out, out_valid, err}, 0);
    end
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req_in = tbl[v].req;
      data_in = tbl[v].data;
      tick(2);
      chk("vec_valid_early", out_valid, 0);
      tick(1);
      chk("vec_valid", out_valid, 1);
      chk("vec_src", out_src, tbl[v].exp_src);
      chk("vec_data", out_data, tbl[v].exp_data);
      chk("vec_ack_pre", ack_out, 0);
      tick(1);
      chk("vec_ack", ack_out, 32'(3'b001 << tbl[v].exp_src));
      chk("vec_valid_off", out_valid, 0);
      req_in = '0;
      tick(2);
      chk("vec_ack_hold", ack_out, 32'(3'b001 << tbl[v].exp_src));
      tick(1);
      chk("vec_ack_fall", ack_out, 0);
      tick(2);
      chk("vec_idle", out_valid, 0);
    end
    // Backpressure: ptr is 2 after the table.
    out_ready = 1'b0;
    req_in = 3'b100;
    data_in = 24'h3C0000;
    tick(3);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("bp_hold", {out_valid, out_data, out_src, ack_out}, {1'b1, 8'h3C, 2'd2, 3'b000});
    end
    out_ready = 1'b1;
    tick(1);
    chk("bp_accept", {out_valid, ack_out}, {1'b0, 3'b100});
    req_in = '0;
    tick(3);
    chk("bp_ack_fall", ack_out, 0);
    // Round-robin contention with re-raising sources.
    do_reset();
    req_in = 3'b111;
    data_in = 24'h332211;
    served = 0;
    for (int c = 0; c < 200 && served < 6; c++) begin
      pv = out_valid;
      ps = out_src;
      pd = out_data;
      tick(1);
      if (pv) begin
        order[served] = ps;
        chk("rr_data", pd, 32'((int'(ps) + 1) * 17));
        served++;
      end
      for (int i = 0; i < N; i++) begin
        if (ack_out[i]) req_in[i] = 1'b0;
        else if (!req_in[i]) req_in[i] = 1'b1;
      end
    end
    chk("rr_count", served, 6);
    for (int k = 0; k < 6; k++) chk("rr_order", order[k], k % 3);
    req_in = '0;
    tick(6);
    // Reset while in WAIT_DROP.
    do_reset();
    req_in = 3'b001;
    data_in = 24'h00005A;
    tick(4);
    chk("rm_ack", ack_out, 3'b001);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rm_cleared", {ack_out, out_valid}, 0);
    rst = 1'b0;
    tick(2);
    chk("rm_wait", out_valid, 0);
    tick(1);
    chk("rm_reserve", {out_valid, out_src, out_data}, {1'b1, 2'd0, 8'h5A});
    tick(1);
    req_in = '0;
    tick(3);
    chk("rm_ack_fall", ack_out, 0);
    // Source 1 never drops its request.
    do_reset();
    req_in = 3'b010;
    data_in = 24'h00A500;
    tick(4);
    chk("to_ack", ack_out, 3'b010);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      tick(1);
      chk("to_ack_wait", {ack_out, err}, (k < TO) ? {3'b010, 1'b0} : {3'b000, 1'b1});
    end
    tick(1);
    chk("to_reserve", {out_valid, out_src, err}, {1'b1, 2'd1, 1'b1});
    tick(5);
    chk("to_err_sticky", err, 1);
    req_in = '0;
    do_reset();
    chk("to_err_clear", err, 0);
`else
    for (int k = 0; k < 30; k++) begin
      tick(1);
      chk("to_hold", {ack_out, err}, {3'b010, 1'b0});
    end
    req_in = '0;
    tick(4);
    chk("to_release", ack_out, 0);
`endif
    // Randomized sources against the transaction model.
    do_reset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      dly[i] = $urandom_range(0, 5);
      oth[i] = 0;
      sd[i] = '0;
    end
    for (int it = 0; it < 3000; it++) begin
      out_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < N; i++) begin
        if (st[i] == 0) begin
          if (dly[i] == 0) begin
            sd[i] = W'($urandom);
            data_in[i*W +: W] = sd[i];
            req_in[i] = 1'b1;
            st[i] = 1;
            oth[i] = 0;
          end else dly[i]--;
        end else if (st[i] == 1) begin
          if (ack_out[i]) begin
            dly[i] = $urandom_range(0, 3);
            st[i] = 2;
          end
        end else if (st[i] == 2) begin
          if (dly[i] != 0) dly[i]--;
          else begin
            req_in[i] = 1'b0;
            st[i] = 3;
          end
        end else if (!ack_out[i]) begin
          dly[i] = $urandom_range(0, 5);
          st[i] = 0;
        end
      end
      pv = out_valid;
      pr = out_ready;
      ps = out_src;
      pd = out_data;
      tick(1);
      chk("rnd_ack_onehot", $onehot0(ack_out), 1);
      if (pv && pr) begin
        chk("rnd_data", pd, sd[ps]);
        chk("rnd_src_req", st[ps], 1);
        chk("rnd_ack", ack_out, 32'(3'b001 << ps));
        for (int i = 0; i < N; i++) begin
          if (i != int'(ps) && st[i] == 1) begin
            oth[i]++;
            chk("rnd_fair", oth[i] <= N - 1, 1);
          end
        end
      end else if (pv) begin
        chk("rnd_hold", {out_valid, out_src, out_data}, {1'b1, ps, pd});
      end
    end
    chk("rnd_err", err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
